// File: rtl/mili_time_sequencer.sv
// Millisecond count to h/m/s/ms converter using one restoring-division step per clock.
// Results, day_ovf and done all update on the same edge so the display never sees a partial value.
module mili_time_sequencer #(
  parameter int unsigned IN_W     = 27,
  parameter int unsigned MS_PER_H = 3600000,
  parameter int unsigned MS_PER_M = 60000,
  parameter int unsigned MS_PER_S = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [IN_W-1:0] inputMili,
  output logic            busy,
  output logic            done,
  output logic [5:0]      outputHours,
  output logic [5:0]      outputMinutes,
  output logic [5:0]      outputSec,
  output logic [9:0]      outputMili,
  output logic            day_ovf
);

  typedef enum logic [1:0] {IDLE, HRS, MIN, SEC} state_t;

  localparam int unsigned XW = IN_W + 6;
  localparam logic [XW-1:0] DH = XW'(MS_PER_H);
  localparam logic [XW-1:0] DM = XW'(MS_PER_M);
  localparam logic [XW-1:0] DS = XW'(MS_PER_S);

  state_t          state, state_nxt;
  logic [2:0]      k;
  logic [IN_W-1:0] rem, rem_nxt;
  logic [5:0]      qh, qm, qs;
  logic [XW-1:0]   dsel, div_sh;
  logic            qbit;
  logic            last_step;

  // One restoring step; widened so D << 5 never truncates. Returns {quotient bit, new remainder}.
  function automatic logic [IN_W:0] div_step(input logic [IN_W-1:0] r,
                                             input logic [XW-1:0]   dsh);
    logic [XW-1:0] rx;
    rx = {6'd0, r};
    if (rx >= dsh) begin
      rx = rx - dsh;
      return {1'b1, rx[IN_W-1:0]};
    end
    return {1'b0, r};
  endfunction

  always_comb begin
    dsel = '0;
    case (state)
      HRS:     dsel = DH;
      MIN:     dsel = DM;
      SEC:     dsel = DS;
      default: dsel = '0;
    endcase
    div_sh            = dsel << k;
    {qbit, rem_nxt}   = div_step(rem, div_sh);
  end

  assign last_step = (state == SEC) && (k == 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = HRS;
      HRS:     if (k == 3'd0) state_nxt = MIN;
      MIN:     if (k == 3'd0) state_nxt = SEC;
      SEC:     if (k == 3'd0) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k             <= 3'd0;
      rem           <= '0;
      qh            <= '0;
      qm            <= '0;
      qs            <= '0;
      done          <= 1'b0;
      outputHours   <= '0;
      outputMinutes <= '0;
      outputSec     <= '0;
      outputMili    <= '0;
      day_ovf       <= 1'b0;
    end else begin
      done <= last_step;
      case (state)
        IDLE: begin
          if (start) begin
            rem <= inputMili;
            k   <= 3'd5;
          end
        end
        HRS, MIN, SEC: begin
          rem <= rem_nxt;
          k   <= (k == 3'd0) ? 3'd5 : k - 3'd1;
          if (state == HRS) qh[k] <= qbit;
          if (state == MIN) qm[k] <= qbit;
          if (state == SEC) qs[k] <= qbit;
          // Final step: qs bit 0 is still in flight, so splice it in directly.
          if (last_step) begin
            outputHours   <= qh;
            outputMinutes <= qm;
            outputSec     <= {qs[5:1], qbit};
            outputMili    <= rem_nxt[9:0];
            day_ovf       <= (qh >= 6'd24);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mili_time_sequencer.sv
// Directed bench for mili_time_sequencer: latency, boundary values, ignored starts, mid-run reset.
module tb_mili_time_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [26:0] inputMili = '0;
  logic        busy, done, day_ovf;
  logic [5:0]  outputHours, outputMinutes, outputSec;
  logic [9:0]  outputMili;

  int n_cmp = 0;
  int n_bad = 0;

  mili_time_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inputMili(inputMili),
    .busy(busy), .done(done), .outputHours(outputHours),
    .outputMinutes(outputMinutes), .outputSec(outputSec),
    .outputMili(outputMili), .day_ovf(day_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [28:0] res();
    return {outputHours, outputMinutes, outputSec, outputMili, day_ovf};
  endfunction

  // Pulse start for one edge, then count edges until done (or -1 after 40).
  task automatic run_conv(input logic [26:0] v, output int lat);
    start = 1'b1;
    inputMili = v;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({busy, done, res()} !== 31'd0) begin
        n_bad++;
        $display("FAIL reset_idle cyc=%0d got busy=%b done=%b res=%h want all 0", i, busy, done, res());
      end
    end
  endtask

  task automatic test_basic();
    int lat;
    run_conv(27'd3723004, lat);
    n_cmp++;
    if (lat !== 18) begin n_bad++; $display("FAIL basic_latency got %0d want 18", lat); end
    n_cmp++;
    if (res() !== {6'd1, 6'd2, 6'd3, 10'd4, 1'b0}) begin
      n_bad++; $display("FAIL basic_result got %h want %h", res(), {6'd1, 6'd2, 6'd3, 10'd4, 1'b0});
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_clear got %b want 0", done); end
  endtask

  task automatic test_day_boundary();
    int lat;
    run_conv(27'd86399999, lat);
    n_cmp++;
    if (lat !== 18 || res() !== {6'd23, 6'd59, 6'd59, 10'd999, 1'b0}) begin
      n_bad++; $display("FAIL day_below lat=%0d got %h want %h", lat, res(), {6'd23, 6'd59, 6'd59, 10'd999, 1'b0});
    end
    run_conv(27'd86400000, lat);
    n_cmp++;
    if (lat !== 18 || res() !== {6'd24, 6'd0, 6'd0, 10'd0, 1'b1}) begin
      n_bad++; $display("FAIL day_exact lat=%0d got %h want %h", lat, res(), {6'd24, 6'd0, 6'd0, 10'd0, 1'b1});
    end
  endtask

  task automatic test_extremes();
    int lat;
    int pulses;
    run_conv(27'd134217727, lat);
    n_cmp++;
    if (lat !== 18 || res() !== {6'd37, 6'd16, 6'd57, 10'd727, 1'b1}) begin
      n_bad++; $display("FAIL max_input lat=%0d got %h want %h", lat, res(), {6'd37, 6'd16, 6'd57, 10'd727, 1'b1});
    end
    run_conv(27'd0, lat);
    n_cmp++;
    if (lat !== 18 || res() !== 29'd0) begin
      n_bad++; $display("FAIL zero_input lat=%0d got %h want 0", lat, res());
    end
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin n_bad++; $display("FAIL zero_single_done extra pulses got %0d want 0", pulses); end
  endtask

  task automatic test_back_to_back();
    int lat;
    start = 1'b1;
    inputMili = 27'd5000;
    @(posedge clk); #1;             // E0
    start = 1'b0;
    inputMili = 27'd999;
    for (int e = 1; e <= 17; e++) begin
      start = (e == 5) || (e == 17);
      @(posedge clk); #1;           // edge e
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        n_bad++; $display("FAIL b2b_busy E%0d got busy=%b done=%b want 1/0", e, busy, done);
      end
    end
    start = 1'b1;                   // held across E18 (ignored) and E19 (accepted)
    @(posedge clk); #1;             // E18
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || res() !== {6'd0, 6'd0, 6'd5, 10'd0, 1'b0}) begin
      n_bad++; $display("FAIL b2b_first done=%b busy=%b got %h want %h", done, busy, res(), {6'd0, 6'd0, 6'd5, 10'd0, 1'b0});
    end
    @(posedge clk); #1;             // E19
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL b2b_accept_E19 got busy=%b done=%b want 1/0", busy, done);
    end
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    n_cmp++;
    if (lat !== 18 || res() !== {6'd0, 6'd0, 6'd0, 10'd999, 1'b0}) begin
      n_bad++; $display("FAIL b2b_second lat=%0d got %h want %h", lat, res(), {6'd0, 6'd0, 6'd0, 10'd999, 1'b0});
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    int pulses;
    start = 1'b1;
    inputMili = 27'd60000;
    @(posedge clk); #1;             // E0
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;                // asynchronous abort around E10
    #1;
    n_cmp++;
    if ({busy, done, res()} !== 31'd0) begin
      n_bad++; $display("FAIL midreset_clear got busy=%b done=%b res=%h want all 0", busy, done, res());
    end
    pulses = 0;
    repeat (3) begin @(posedge clk); #1; if (done) pulses++; end
    rst_n = 1'b1;
    repeat (20) begin @(posedge clk); #1; if (done || busy) pulses++; end
    n_cmp++;
    if (pulses !== 0) begin n_bad++; $display("FAIL midreset_no_done got %0d activity cycles want 0", pulses); end
    run_conv(27'd61001, lat);
    n_cmp++;
    if (lat !== 18 || res() !== {6'd0, 6'd1, 6'd1, 10'd1, 1'b0}) begin
      n_bad++; $display("FAIL midreset_after lat=%0d got %h want %h", lat, res(), {6'd0, 6'd1, 6'd1, 10'd1, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_day_boundary();
    test_extremes();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
